// File: rtl/cpu6_ifu_ibuf.sv
// cpu6 instruction buffer: small circular FIFO of {pc, instr} between fetch and decode.
// Optional zero-latency empty-buffer bypass enabled by defining CPU6_IBUF_BYPASS_EN.
module cpu6_ifu_ibuf #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTRW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_pc,
  input  logic [DW-1:0]   in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_pc,
  output logic [DW-1:0]   out_instr,
  output logic [PTRW:0]   count
);

  localparam int unsigned CW = PTRW + 1;

  logic [AW-1:0]   pc_mem    [DEPTH];
  logic [DW-1:0]   instr_mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW:0]   cnt;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign in_ready = ~full;
  assign count    = cnt;

`ifdef CPU6_IBUF_BYPASS_EN
  logic byp;

  // Empty buffer forwards fetch straight to decode; consumed entries are never written.
  assign byp       = empty & in_valid & ~flush;
  assign out_valid = ~empty | byp;
  assign out_pc    = byp ? in_pc    : pc_mem[rd_ptr];
  assign out_instr = byp ? in_instr : instr_mem[rd_ptr];
  assign push      = in_valid & in_ready & ~flush & ~(byp & out_ready);
  assign pop       = ~empty & out_ready & ~flush;
`else
  assign out_valid = ~empty;
  assign out_pc    = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
`endif

  // Storage flops: load-enable only, not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  // Pointers wrap naturally at DEPTH; count alone separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6_ifu_ibuf.sv
// Self-checking bench for cpu6_ifu_ibuf: directed vector table, streaming/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_cpu6_ifu_ibuf;

`ifdef CPU6_IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  cpu6_ifu_ibuf #(.DW(32), .AW(32), .DEPTH(4), .PTRW(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        ordy;
    logic        eov;
    logic        eir;
    logic [2:0]  ecnt;
    logic [31:0] epc;
    logic [31:0] eins;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] pc,
                              input logic [31:0] ins, input logic ordy, input logic eov,
                              input logic eir, input logic [2:0] ecnt,
                              input logic [31:0] epc, input logic [31:0] eins);
    vec_t v;
    v.fl = fl; v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy;
    v.eov = eov; v.eir = eir; v.ecnt = ecnt; v.epc = epc; v.eins = eins;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ordy);
    flush = fl; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
  endtask

  // Reference model state: oldest entry at index 0.
  logic [63:0] q[$];

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_count", 64'(count), 64'd0);
    @(posedge clk); #1;

    // Directed table: expected values are pre-edge outputs for that row's cycle
    tbl[0]  = mk(0, 1, 32'h100, 32'hA0, 0, BYP, 1, 3'd0, 32'h100, 32'hA0);
    tbl[1]  = mk(0, 1, 32'h104, 32'hA1, 0, 1, 1, 3'd1, 32'h100, 32'hA0);
    tbl[2]  = mk(0, 1, 32'h108, 32'hA2, 0, 1, 1, 3'd2, 32'h100, 32'hA0);
    tbl[3]  = mk(0, 1, 32'h10C, 32'hA3, 0, 1, 1, 3'd3, 32'h100, 32'hA0);
    tbl[4]  = mk(0, 1, 32'h110, 32'hA4, 0, 1, 0, 3'd4, 32'h100, 32'hA0);
    tbl[5]  = mk(0, 0, 32'h0,   32'h0,  1, 1, 0, 3'd4, 32'h100, 32'hA0);
    tbl[6]  = mk(0, 0, 32'h0,   32'h0,  1, 1, 1, 3'd3, 32'h104, 32'hA1);
    tbl[7]  = mk(0, 0, 32'h0,   32'h0,  1, 1, 1, 3'd2, 32'h108, 32'hA2);
    tbl[8]  = mk(0, 0, 32'h0,   32'h0,  1, 1, 1, 3'd1, 32'h10C, 32'hA3);
    tbl[9]  = mk(0, 0, 32'h0,   32'h0,  0, 0, 1, 3'd0, 32'h0,   32'h0);
    tbl[10] = mk(0, 1, 32'h200, 32'hB0, 0, BYP, 1, 3'd0, 32'h200, 32'hB0);
    tbl[11] = mk(0, 1, 32'h204, 32'hB1, 0, 1, 1, 3'd1, 32'h200, 32'hB0);
    tbl[12] = mk(0, 1, 32'h208, 32'hB2, 0, 1, 1, 3'd2, 32'h200, 32'hB0);
    tbl[13] = mk(0, 1, 32'h20C, 32'hB3, 0, 1, 1, 3'd3, 32'h200, 32'hB0);
    tbl[14] = mk(0, 1, 32'h300, 32'hC0, 1, 1, 0, 3'd4, 32'h200, 32'hB0);
    tbl[15] = mk(0, 0, 32'h0,   32'h0,  0, 1, 1, 3'd3, 32'h204, 32'hB1);
    tbl[16] = mk(1, 1, 32'h400, 32'hD0, 1, 1, 1, 3'd3, 32'h204, 32'hB1);
    tbl[17] = mk(0, 0, 32'h0,   32'h0,  0, 0, 1, 3'd0, 32'h0,   32'h0);
    tbl[18] = mk(0, 0, 32'h0,   32'h0,  1, 0, 1, 3'd0, 32'h0,   32'h0);
    tbl[19] = mk(0, 1, 32'h500, 32'hE0, 1, BYP, 1, 3'd0, 32'h500, 32'hE0);
    tbl[20] = mk(0, 0, 32'h0,   32'h0,  0, !BYP, 1, BYP ? 3'd0 : 3'd1, 32'h500, 32'hE0);
    tbl[21] = mk(0, 0, 32'h0,   32'h0,  1, !BYP, 1, BYP ? 3'd0 : 3'd1, 32'h500, 32'hE0);
    tbl[22] = mk(0, 0, 32'h0,   32'h0,  0, 0, 1, 3'd0, 32'h0,   32'h0);

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].ins, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].eov));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].eir));
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].ecnt));
      if (tbl[i].eov) begin
        chk($sformatf("vec%0d_out_pc", i), 64'(out_pc), 64'(tbl[i].epc));
        chk($sformatf("vec%0d_out_instr", i), 64'(out_instr), 64'(tbl[i].eins));
      end
      @(posedge clk); #1;
    end

    // Streaming at count=2: pointers wrap several times, order preserved
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 32'h600 + 32'(4 * k), 32'hF00 + 32'(k), 0);
      @(posedge clk); #1;
    end
    for (int j = 0; j < 10; j++) begin
      drive(0, 1, 32'h608 + 32'(4 * j), 32'hF02 + 32'(j), 1);
      @(negedge clk);
      chk($sformatf("stream%0d_count", j), 64'(count), 64'd2);
      chk($sformatf("stream%0d_out_pc", j), 64'(out_pc), 64'(32'h600 + 32'(4 * j)));
      chk($sformatf("stream%0d_out_instr", j), 64'(out_instr), 64'(32'hF00 + 32'(j)));
      @(posedge clk); #1;
    end
    for (int j = 10; j < 12; j++) begin
      drive(0, 0, 32'h0, 32'h0, 1);
      @(negedge clk);
      chk($sformatf("drain%0d_out_pc", j), 64'(out_pc), 64'(32'h600 + 32'(4 * j)));
      @(posedge clk); #1;
    end
    drive(0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("drain_empty_count", 64'(count), 64'd0);
    @(posedge clk); #1;

    // Randomized traffic against the queue model
    q.delete();
    for (int c = 0; c < 400; c++) begin
      logic fl, iv, ordy, eov, eir, byp_now;
      logic [31:0] pc, ins;
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      pc   = $urandom;
      ins  = $urandom;
      drive(fl, iv, pc, ins, ordy);
      byp_now = BYP && (q.size() == 0) && iv && !fl;
      eov = (q.size() != 0) || byp_now;
      eir = (q.size() != DEPTH);
      @(negedge clk);
      chk("rnd_count", 64'(count), 64'(q.size()));
      chk("rnd_out_valid", 64'(out_valid), 64'(eov));
      chk("rnd_in_ready", 64'(in_ready), 64'(eir));
      if (eov) begin
        if (byp_now) chk("rnd_out_head", {out_pc, out_instr}, {pc, ins});
        else         chk("rnd_out_head", {out_pc, out_instr}, q[0]);
      end
      @(posedge clk); #1;
      if (fl) q.delete();
      else if (byp_now && ordy) begin
        // consumed directly, nothing stored
      end else begin
        if (eov && ordy) void'(q.pop_front());
        if (iv && eir) q.push_back({pc, ins});
      end
    end

    // Asynchronous reset mid-operation
    drive(0, 1, 32'h700, 32'h70, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    drive(0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 1, 32'h800, 32'h80, 0);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 32'h0, 1);
    @(negedge clk);
    chk("after_rst_count", 64'(count), 64'd1);
    chk("after_rst_out_pc", 64'(out_pc), 64'h800);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
